control_unit: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 102 ++++++++++
 rtl/control_decode.sv | 100 ++++++++++
 rtl/control_unit.sv | 123 ++++++++++++
 tb/tb_control_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired CPU control unit: opcodes, ALU
// function codes, sequencer states and the bundled control-strobe vector.
package cpu_ctrl_pkg;

    // Instruction opcodes, taken from instruction[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU function codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    // Sequencer states: reset, the eight timing steps, and the halted sink
    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
        T6      = 4'd7,
        T7      = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    // Instructions grouped by the shape of their execute sequence
    typedef enum logic [2:0] {
        CLS_REG  = 3'd0,
        CLS_IMM  = 3'd1,
        CLS_LDI  = 3'd2,
        CLS_LD   = 3'd3,
        CLS_ST   = 3'd4,
        CLS_NOP  = 3'd5,
        CLS_HALT = 3'd6
    } op_class_t;

    // Every strobe the sequencer drives, bundled so the decoder has one output
    typedef struct packed {
        logic       PCout;
        logic       PCin;
        logic       IncPC;
        logic       MARin;
        logic       MDRin;
        logic       MDRout;
        logic       IRin;
        logic       Read;
        logic       Write;
        logic       Yin;
        logic       Zin;
        logic       Zlowout;
        logic       Cout;
        logic       Gra;
        logic       Grb;
        logic       Grc;
        logic       Rin;
        logic       Rout;
        logic       BAout;
        logic [3:0] alu_op;
        logic       run;
    } ctrl_t;

    // Sort an opcode into its execute-sequence class; unknown codes halt
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_REG;
            OP_ADDI, OP_ANDI, OP_ORI:      cls = CLS_IMM;
            OP_LDI:                        cls = CLS_LDI;
            OP_LD:                         cls = CLS_LD;
            OP_ST:                         cls = CLS_ST;
            OP_NOP:                        cls = CLS_NOP;
            default:                       cls = CLS_HALT;
        endcase
        return cls;
    endfunction

    // ALU function used in the T4 step; address arithmetic always adds
    function automatic logic [3:0] alu_code(input logic [4:0] op);
        logic [3:0] code;
        case (op)
            OP_SUB:          code = ALU_SUB;
            OP_AND, OP_ANDI: code = ALU_AND;
            OP_OR, OP_ORI:   code = ALU_OR;
            default:         code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Pure output decode for the control unit: maps the current state and the
// latched opcode to the full set of datapath strobes.
module control_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] op_q,
    output ctrl_t      ctrl
);

    op_class_t cls;

    assign cls = classify(op_q);

    // Moore decode: everything defaults low, each step raises only its strobes
    always_comb begin
        ctrl = '0;
        case (state)
            T0: begin
                ctrl.run   = 1'b1;
                ctrl.PCout = 1'b1;
                ctrl.MARin = 1'b1;
                ctrl.IncPC = 1'b1;
            end
            T1: begin
                ctrl.run   = 1'b1;
                ctrl.Read  = 1'b1;
                ctrl.MDRin = 1'b1;
            end
            T2: begin
                ctrl.run    = 1'b1;
                ctrl.MDRout = 1'b1;
                ctrl.IRin   = 1'b1;
            end
            T3: begin
                ctrl.run = 1'b1;
                case (cls)
                    CLS_REG, CLS_IMM: begin
                        ctrl.Grb  = 1'b1;
                        ctrl.Rout = 1'b1;
                        ctrl.Yin  = 1'b1;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        ctrl.Grb   = 1'b1;
                        ctrl.BAout = 1'b1;
                        ctrl.Yin   = 1'b1;
                    end
                    default: begin
                        ctrl.run = 1'b1;
                    end
                endcase
            end
            T4: begin
                ctrl.run    = 1'b1;
                ctrl.Zin    = 1'b1;
                ctrl.alu_op = alu_code(op_q);
                if (cls == CLS_REG) begin
                    ctrl.Grc  = 1'b1;
                    ctrl.Rout = 1'b1;
                end else begin
                    ctrl.Cout = 1'b1;
                end
            end
            T5: begin
                ctrl.run     = 1'b1;
                ctrl.Zlowout = 1'b1;
                if (cls == CLS_LD || cls == CLS_ST) begin
                    ctrl.MARin = 1'b1;
                end else begin
                    ctrl.Gra = 1'b1;
                    ctrl.Rin = 1'b1;
                end
            end
            T6: begin
                ctrl.run   = 1'b1;
                ctrl.MDRin = 1'b1;
                if (cls == CLS_ST) begin
                    ctrl.Gra  = 1'b1;
                    ctrl.Rout = 1'b1;
                end else begin
                    ctrl.Read = 1'b1;
                end
            end
            T7: begin
                ctrl.run = 1'b1;
                if (cls == CLS_ST) begin
                    ctrl.Write = 1'b1;
                end else begin
                    ctrl.MDRout = 1'b1;
                    ctrl.Gra    = 1'b1;
                    ctrl.Rin    = 1'b1;
                end
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer for the CPU datapath. Holds the state register and the
// latched opcode, computes the next step, and hands output decoding to
// control_decode so every strobe is a function of registered state only.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Read,
    output logic        Write,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [3:0]  alu_op,
    output logic        run
);

    state_t     state;
    state_t     next_state;
    logic [4:0] op_q;
    op_class_t  cls;
    ctrl_t      ctrl;
    logic       unused_instr_bits;

    // Only the opcode field matters to sequencing; operand fields go to select-and-encode
    assign unused_instr_bits = ^instruction[26:0];

    assign cls = classify(op_q);

    // Next-step selection; memory steps hold until mem_ready completes them
    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = T0;
            T0:      next_state = T1;
            T1:      next_state = mem_ready ? T2 : T1;
            T2:      next_state = T3;
            T3: begin
                case (cls)
                    CLS_NOP:  next_state = T0;
                    CLS_HALT: next_state = S_HALT;
                    default:  next_state = T4;
                endcase
            end
            T4:      next_state = T5;
            T5:      next_state = (cls == CLS_LD || cls == CLS_ST) ? T6 : T0;
            T6: begin
                if (cls == CLS_ST) begin
                    next_state = T7;
                end else begin
                    next_state = mem_ready ? T7 : T6;
                end
            end
            T7: begin
                if (cls == CLS_ST) begin
                    next_state = mem_ready ? T0 : T7;
                end else begin
                    next_state = T0;
                end
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

    // State register and opcode capture on the way into the decode step
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
            op_q  <= OP_NOP;
        end else begin
            state <= next_state;
            if (state == T2) begin
                op_q <= instruction[31:27];
            end
        end
    end

    control_decode u_decode (
        .state (state),
        .op_q  (op_q),
        .ctrl  (ctrl)
    );

    assign PCout   = ctrl.PCout;
    assign PCin    = ctrl.PCin;
    assign IncPC   = ctrl.IncPC;
    assign MARin   = ctrl.MARin;
    assign MDRin   = ctrl.MDRin;
    assign MDRout  = ctrl.MDRout;
    assign IRin    = ctrl.IRin;
    assign Read    = ctrl.Read;
    assign Write   = ctrl.Write;
    assign Yin     = ctrl.Yin;
    assign Zin     = ctrl.Zin;
    assign Zlowout = ctrl.Zlowout;
    assign Cout    = ctrl.Cout;
    assign Gra     = ctrl.Gra;
    assign Grb     = ctrl.Grb;
    assign Grc     = ctrl.Grc;
    assign Rin     = ctrl.Rin;
    assign Rout    = ctrl.Rout;
    assign BAout   = ctrl.BAout;
    assign alu_op  = ctrl.alu_op;
    assign run     = ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a step-list reference model built
// from each instruction's micro-sequence, random memory wait states and
// random instruction mixes, plus reset, halt and illegal-opcode scenarios.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic        mem_ready = 1'b0;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write;
    logic Yin, Zin, Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, run;
    logic [3:0] alu_op;

    int checks = 0;
    int failures = 0;

    // Observed strobe vector, one bit per signal plus the ALU field
    localparam logic [23:0] M_PCOUT   = 24'h1 << 23;
    localparam logic [23:0] M_INCPC   = 24'h1 << 21;
    localparam logic [23:0] M_MARIN   = 24'h1 << 20;
    localparam logic [23:0] M_MDRIN   = 24'h1 << 19;
    localparam logic [23:0] M_MDROUT  = 24'h1 << 18;
    localparam logic [23:0] M_IRIN    = 24'h1 << 17;
    localparam logic [23:0] M_READ    = 24'h1 << 16;
    localparam logic [23:0] M_WRITE   = 24'h1 << 15;
    localparam logic [23:0] M_YIN     = 24'h1 << 14;
    localparam logic [23:0] M_ZIN     = 24'h1 << 13;
    localparam logic [23:0] M_ZLOWOUT = 24'h1 << 12;
    localparam logic [23:0] M_COUT    = 24'h1 << 11;
    localparam logic [23:0] M_GRA     = 24'h1 << 10;
    localparam logic [23:0] M_GRB     = 24'h1 << 9;
    localparam logic [23:0] M_GRC     = 24'h1 << 8;
    localparam logic [23:0] M_RIN     = 24'h1 << 7;
    localparam logic [23:0] M_ROUT    = 24'h1 << 6;
    localparam logic [23:0] M_BAOUT   = 24'h1 << 5;
    localparam logic [23:0] M_RUN     = 24'h1;
    localparam logic [23:0] M_BUS     = M_PCOUT | M_MDROUT | M_ZLOWOUT | M_COUT | M_ROUT | M_BAOUT;

    logic [23:0] obs;
    assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write,
                  Yin, Zin, Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run};

    // Legal opcodes other than halt, used for the random instruction mix
    logic [4:0] legal_ops [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                   5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110,
                                   5'b11010};

    always #5 clock = ~clock;

    control_unit dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .mem_ready   (mem_ready),
        .PCout       (PCout),
        .PCin        (PCin),
        .IncPC       (IncPC),
        .MARin       (MARin),
        .MDRin       (MDRin),
        .MDRout      (MDRout),
        .IRin        (IRin),
        .Read        (Read),
        .Write       (Write),
        .Yin         (Yin),
        .Zin         (Zin),
        .Zlowout     (Zlowout),
        .Cout        (Cout),
        .Gra         (Gra),
        .Grb         (Grb),
        .Grc         (Grc),
        .Rin         (Rin),
        .Rout        (Rout),
        .BAout       (BAout),
        .alu_op      (alu_op),
        .run         (run)
    );

    task automatic checkOutput(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: execute-sequence kind for an opcode (0 reg, 1 imm, 2 ldi, 3 ld, 4 st, 5 nop, 6 halt)
    function automatic int opKind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return 0;
            5'b01100, 5'b01101, 5'b01110:           return 1;
            5'b00001:                               return 2;
            5'b00000:                               return 3;
            5'b00010:                               return 4;
            5'b11010:                               return 5;
            default:                                return 6;
        endcase
    endfunction

    // Reference: ALU field as it appears in the strobe vector during T4
    function automatic logic [23:0] aluField(input logic [4:0] op);
        int code;
        case (op)
            5'b00100:           code = 1;
            5'b00101, 5'b01101: code = 2;
            5'b00110, 5'b01110: code = 3;
            default:            code = 0;
        endcase
        return 24'(code) << 1;
    endfunction

    // Every cycle: the vector must be exactly the model's, with at most one bus driver
    task automatic checkCycle(input string tag, input logic [23:0] exp);
        checkOutput(tag, obs, exp);
        checkOutput({tag, "_bus"}, {23'd0, ($countones(obs & M_BUS) <= 1)}, 24'd1);
    endtask

    // Asynchronous reset mid-cycle, held for hold_cycles, released at a falling edge
    task automatic doReset(input int hold_cycles);
        #2 reset = 1'b1;
        #1 checkOutput("reset_async", obs, 24'd0);
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clock);
            checkOutput($sformatf("reset_hold%0d", c), obs, 24'd0);
        end
        reset = 1'b0;
        mem_ready = 1'b1;
        #1 checkOutput("reset_release", obs, 24'd0);
    endtask

    // Walk one instruction through the model's step list, starting at its T0 cycle.
    // fixed_wait < 0 picks random wait states; abort_step >= 0 resets during that step.
    task automatic applyStimulus(input logic [31:0] instr, input int fixed_wait, input int abort_step);
        logic [23:0] steps [$];
        bit          mem_step [$];
        logic [4:0]  op;
        int          kind;
        int          waits;
        op = instr[31:27];
        kind = opKind(op);
        instruction = instr;
        steps.push_back(M_PCOUT | M_MARIN | M_INCPC | M_RUN);  mem_step.push_back(1'b0);
        steps.push_back(M_READ | M_MDRIN | M_RUN);             mem_step.push_back(1'b1);
        steps.push_back(M_MDROUT | M_IRIN | M_RUN);            mem_step.push_back(1'b0);
        case (kind)
            0, 1: begin
                steps.push_back(M_GRB | M_ROUT | M_YIN | M_RUN); mem_step.push_back(1'b0);
                if (kind == 0) steps.push_back(M_GRC | M_ROUT | M_ZIN | aluField(op) | M_RUN);
                else           steps.push_back(M_COUT | M_ZIN | aluField(op) | M_RUN);
                mem_step.push_back(1'b0);
                steps.push_back(M_ZLOWOUT | M_GRA | M_RIN | M_RUN); mem_step.push_back(1'b0);
            end
            2, 3, 4: begin
                steps.push_back(M_GRB | M_BAOUT | M_YIN | M_RUN); mem_step.push_back(1'b0);
                steps.push_back(M_COUT | M_ZIN | M_RUN);          mem_step.push_back(1'b0);
                if (kind == 2) begin
                    steps.push_back(M_ZLOWOUT | M_GRA | M_RIN | M_RUN); mem_step.push_back(1'b0);
                end else begin
                    steps.push_back(M_ZLOWOUT | M_MARIN | M_RUN); mem_step.push_back(1'b0);
                    if (kind == 3) begin
                        steps.push_back(M_READ | M_MDRIN | M_RUN);          mem_step.push_back(1'b1);
                        steps.push_back(M_MDROUT | M_GRA | M_RIN | M_RUN);  mem_step.push_back(1'b0);
                    end else begin
                        steps.push_back(M_GRA | M_ROUT | M_MDRIN | M_RUN);  mem_step.push_back(1'b0);
                        steps.push_back(M_WRITE | M_RUN);                   mem_step.push_back(1'b1);
                    end
                end
            end
            default: begin
                steps.push_back(M_RUN); mem_step.push_back(1'b0);
            end
        endcase
        for (int i = 0; i < steps.size(); i++) begin
            if (i == abort_step) begin
                @(negedge clock);
                checkCycle($sformatf("op%b_s%0d_pre_abort", op, i), steps[i]);
                mem_ready = 1'b0;
                doReset(2);
                return;
            end
            if (mem_step[i]) begin
                waits = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
                for (int c = 0; c <= waits; c++) begin
                    @(negedge clock);
                    checkCycle($sformatf("op%b_s%0d_w%0d", op, i, c), steps[i]);
                    mem_ready = (c == waits);
                end
            end else begin
                @(negedge clock);
                checkCycle($sformatf("op%b_s%0d", op, i), steps[i]);
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
        if (kind == 6) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clock);
                mem_ready = 1'($urandom_range(0, 1));
                instruction = $urandom();
                checkOutput($sformatf("halted_c%0d", c), obs, 24'd0);
            end
        end
    endtask

    initial begin
        @(negedge clock);
        doReset(3);
        // add r3, r1, r2 with zero-wait memory
        applyStimulus({5'b00011, 4'd3, 4'd1, 4'd2, 15'd0}, 0, -1);
        // ld with two wait cycles on each memory access
        applyStimulus({5'b00000, 4'd5, 4'd2, 19'd16}, 2, -1);
        // st with zero-wait memory
        applyStimulus({5'b00010, 4'd4, 4'd6, 19'd8}, 0, -1);
        // random instruction mix with random wait states
        for (int n = 0; n < 60; n++) begin
            logic [26:0] fields;
            fields = 27'($urandom());
            applyStimulus({legal_ops[$urandom_range(0, 10)], fields}, -1, -1);
        end
        // halt, then an illegal opcode after a fresh reset
        applyStimulus({5'b11011, 27'd0}, -1, -1);
        doReset(2);
        applyStimulus({5'b11111, 27'd0}, -1, -1);
        doReset(2);
        // reset asynchronously while ld waits in T6, then restart cleanly
        applyStimulus({5'b00000, 4'd1, 4'd2, 19'd4}, 0, 6);
        applyStimulus({5'b01101, 4'd2, 4'd7, 19'd3}, -1, -1);
        applyStimulus({5'b11010, 27'd0}, -1, -1);
        applyStimulus({5'b00100, 4'd1, 4'd2, 4'd3, 15'd0}, -1, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
